// File: rtl/tp_mem_param.sv
// tp_mem_param: ping-pong N x N block memory; rows in, transposed (or passed-through) vectors out.
// Optional TPMEM_MODE_EN adds i_mode, sampled per block, selecting pass-through instead of transpose.
module tp_mem_param #(
  parameter int BW  = 12,
  parameter int N   = 6,
  parameter int PAD = 2
) (
  input  logic                  i_clk,
  input  logic                  i_Reset,
  input  logic [N*BW-1:0]       i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [(N+PAD)*BW-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
`ifdef TPMEM_MODE_EN
  ,
  input  logic                  i_mode
`endif
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N*BW-1:0] mem [2][N];
  logic [1:0] full, full_n;
  logic wr_ptr, rd_ptr;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic wr_en, rd_en, wr_done, rd_done, pass;
  logic [(N+PAD)*BW-1:0] vec;

  assign o_ready = ~full[wr_ptr];
  assign wr_en   = i_valid && o_ready;
  assign wr_done = wr_en && wr_cnt == LAST;
  assign rd_en   = full[rd_ptr] && (!o_valid || i_ready);
  assign rd_done = rd_en && rd_cnt == LAST;

`ifdef TPMEM_MODE_EN
  logic [1:0] mode;
  assign pass = mode[rd_ptr];
`else
  assign pass = 1'b0;
`endif

  // Element i of vector rd_cnt: column rd_cnt of row i (transpose) or row rd_cnt column i.
  always_comb begin
    vec = '0;
    for (int i = 0; i < N; i++)
      vec[(N+PAD-i)*BW-1 -: BW] = pass ? mem[rd_ptr][rd_cnt][(N-i)*BW-1 -: BW]
                                       : mem[rd_ptr][i][(N-1-int'(rd_cnt))*BW +: BW];
  end

  // A read-side free and a write-side fill always touch different banks.
  always_comb begin
    full_n = full;
    if (rd_done) full_n[rd_ptr] = 1'b0;
    if (wr_done) full_n[wr_ptr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr][wr_cnt] <= i_data;
`ifdef TPMEM_MODE_EN
    if (wr_en && wr_cnt == '0) mode[wr_ptr] <= i_mode;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      full    <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_en) begin
        wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
        wr_ptr <= wr_ptr ^ wr_done;
      end
      if (rd_en) begin
        o_data  <= vec;
        o_valid <= 1'b1;
        o_last  <= rd_done;
        rd_cnt  <= rd_done ? '0 : rd_cnt + 1'b1;
        rd_ptr  <= rd_ptr ^ rd_done;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end
endmodule
